// File: rtl/multiword_add_ctrl.sv
// Multi-word adder/subtractor controller.
//
// Adds or subtracts two W = BITS*WORDS bit operands one BITS-wide chunk per
// cycle through a single carry-lookahead adder. The carry between chunks
// passes only through a carry register. Valid/ready handshakes sit on both
// sides. Latency is WORDS+1 cycles from the input handshake to out_valid.
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand set present
//   in_ready  : block is idle and can accept operands
//   A, B      : W-bit operands
//   Cin       : carry-in (add only)
//   Sub       : 0 = A+B+Cin, 1 = A-B
//   out_valid : result present (held until out_ready)
//   out_ready : consumer accepts result
//   Sum       : W-bit result (qualified only by out_valid)
//   Cout      : carry out of bit W-1 (subtract: 1 = no borrow)
//   Ovf       : signed two's-complement overflow

// BITS-wide carry-lookahead adder. Each carry is a flat sum of products of
// generate/propagate terms, not a ripple chain.
module multiword_add_cla #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);
    logic [BITS-1:0] g;
    logic [BITS-1:0] p;
    logic [BITS:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic acc;
        logic prod;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < BITS; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & cin);
        end
    end

    assign sum  = p ^ c[BITS-1:0];
    assign cout = c[BITS];
endmodule

module multiword_add_ctrl #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS*WORDS-1:0] A,
    input  logic [BITS*WORDS-1:0] B,
    input  logic                  Cin,
    input  logic                  Sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS*WORDS-1:0] Sum,
    output logic                  Cout,
    output logic                  Ovf
);
    localparam int unsigned W  = BITS * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] KLast = KW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;     // B already inverted for subtract
    logic            carry;
    logic [KW-1:0]   k;

    logic [BITS-1:0] a_chunk;
    logic [BITS-1:0] b_chunk;
    logic [BITS-1:0] cla_sum;
    logic            cla_cout;

    assign a_chunk = a_reg[k*BITS +: BITS];
    assign b_chunk = b_reg[k*BITS +: BITS];

    multiword_add_cla #(
        .BITS (BITS)
    ) u_cla (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= B ^ {W{Sub}};
                        // Subtract is A + ~B + 1; Cin is ignored then.
                        carry <= Sub ? 1'b1 : Cin;
                        k     <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    Sum[k*BITS +: BITS] <= cla_sum;
                    carry <= cla_cout;
                    if (k == KLast) begin
                        Cout  <= cla_cout;
                        // Operand signs agree but result sign differs.
                        Ovf   <= (a_chunk[BITS-1] == b_chunk[BITS-1]) &
                                 (cla_sum[BITS-1] != a_chunk[BITS-1]);
                        state <= StDone;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
module tb_multiword_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        Sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;
    logic        Cout;
    logic        Ovf;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multiword_add_ctrl #(
        .BITS  (8),
        .WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call one #1 after the handshake edge. The handshake cycle counts as cycle 1.
    task automatic wait_result(input string tag, input logic [31:0] es, input logic ec,
                               input logic eo);
        int cnt;
        cnt = 1;
        while (!out_valid && cnt < 30) begin
            step();
            cnt++;
        end
        check({tag, " latency"}, cnt, 32'd5);
        check({tag, " sum"}, Sum, es);
        check({tag, " cout"}, {31'd0, Cout}, {31'd0, ec});
        check({tag, " ovf"}, {31'd0, Ovf}, {31'd0, eo});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " in_ready after release"}, {31'd0, in_ready}, 32'd1);
        check({tag, " out_valid after release"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub);
        A = a;
        B = b;
        Cin = cin;
        Sub = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble inputs after the handshake; the result must not depend on them.
        A = $urandom;
        B = $urandom;
        Cin = 1'($urandom);
        Sub = 1'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo);
        start_op(a, b, cin, sub);
        check({tag, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
        wait_result(tag, es, ec, eo);
        release_result(tag);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        Sub = 1'b0;
        step();
        step();
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset sum", Sum, 32'd0);
        check("reset cout", {31'd0, Cout}, 32'd0);
        check("reset ovf", {31'd0, Ovf}, 32'd0);

        // Reset wins over a simultaneous handshake.
        in_valid = 1'b1;
        A = 32'h1;
        B = 32'h1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst priority in_ready", {31'd0, in_ready}, 32'd1);

        do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op("sub neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub pos", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        do_op("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);

        // Back-pressure in DONE while a new operand set is offered.
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        wait_result("hold", 32'h0000_0030, 1'b0, 1'b0);
        held = Sum;
        A = 32'h0000_0001;
        B = 32'h0000_0002;
        Cin = 1'b0;
        Sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold sum", Sum, held);
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold idle in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("hold new accepted", {31'd0, in_ready}, 32'd0);
        wait_result("after hold", 32'h0000_0003, 1'b0, 1'b0);
        release_result("after hold");

        // Reset during the second RUN cycle aborts the operation.
        start_op(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort sum", Sum, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("abort no out_valid", seen, 32'd0);
        end
        do_op("post abort", 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'h0303_0303, 1'b0,
              1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter BITS, default 8: width of one CLA chunk; the block instantiates exactly one CLA #(BITS).
REQ-002 Parameter WORDS, default 4: chunks per operand; full width W = BITS*WORDS.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 A  input  W  operand A.
REQ-008 B  input  W  operand B.
REQ-009 Cin  input  1  carry-in, used for add only.
REQ-010 Sub  input  1  0 = A+B+Cin; 1 = A-B.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 Sum  output  W  result.
REQ-014 Cout  output  1  carry out of bit W-1 (for subtract, 1 = no borrow).
REQ-015 Ovf  output  1  two's-complement signed overflow of the full W-bit operation.

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Input handshake at cycle T (in_valid & in_ready): latch A, B^{W{Sub}}, and carry seed c0 = Sub ? 1 : Cin; clear chunk index k to 0; go to RUN.
REQ-018 RUN, cycle T+1+k (k = 0..WORDS-1): drive CLA with A chunk k, latched-B chunk k, and carry register; write CLA Sum to Sum[k*BITS +: BITS]; load CLA Cout into carry register.
REQ-019 Only one chunk is processed per cycle; carry propagates between chunks only through the carry register.
REQ-020 After chunk WORDS-1 (cycle T+WORDS): Cout = final carry; Ovf = (A[W-1] == Beff[W-1]) & (Sum[W-1] != A[W-1]), where Beff is the latched, possibly inverted B; go to DONE.
REQ-021 out_valid first asserts at cycle T+WORDS+1; latency is WORDS+1 cycles from input handshake.
REQ-022 In DONE, Sum/Cout/Ovf stay stable until out_valid & out_ready; state then returns to IDLE and in_ready rises the following cycle.
REQ-023 No input is accepted in RUN or DONE; in_valid there has no effect, and A/B/Cin/Sub changes after the handshake do not affect the result.
REQ-024 Sum chunks not yet written in RUN hold their previous values; only out_valid qualifies Sum.
REQ-025 WORDS=1 is legal: a single RUN cycle, latency 2.
REQ-026 Arithmetic is modulo 2^W; wrap-around is reported only via Cout/Ovf.

Reset
REQ-027 While rst is high at a clock edge: state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, carry register=0, k=0.
REQ-028 Reset during RUN or DONE aborts the operation and discards its result; out_valid never asserts for it.
REQ-029 rst has priority over any simultaneous handshake in the same cycle.

Verification (BITS=8, WORDS=4)
REQ-030 A=0xFFFFFFFF, B=0x00000001, Cin=0, Sub=0 -> out_valid at T+5, Sum=0x00000000, Cout=1, Ovf=0.
REQ-031 A=0x7FFFFFFF, B=0x00000001, Cin=0, Sub=0 -> Sum=0x80000000, Cout=0, Ovf=1.
REQ-032 A=0x000000FF, B=0x00000000, Cin=1, Sub=0 -> Sum=0x00000100, Cout=0, Ovf=0; confirms inter-chunk carry.
REQ-033 Sub=1, A=0x00000005, B=0x00000007, Cin=1 (ignored) -> Sum=0xFFFFFFFE, Cout=0, Ovf=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while driving new in_valid=1 -> Sum/Cout/Ovf stable, in_ready=0, new input ignored; set out_ready=1 -> IDLE next cycle, then the new input is accepted.
REQ-035 Assert rst during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, Sum=0; the next operation completes normally with latency 5.
